// File: rtl/lsu_pkg.sv
// Shared types and pure helpers for the load/store unit: funct3 codes,
// FSM state type, store byte-enable generation and write-data replication.
package lsu_pkg;

  localparam int LSU_DEPTH_WORDS = 256;
  localparam int LSU_TAG_W       = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } lsu_state_t;

  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << addr_lo;
      F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wd_replicate(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] wd;
    case (funct3)
      F3_B:    wd = {4{wdata[7:0]}};
      F3_H:    wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

  function automatic logic f3_legal(input logic store, input logic [2:0] funct3);
    if (store) return funct3 inside {F3_B, F3_H, F3_W};
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Access size comes from funct3[1:0] (00 byte, 01 half, 10 word).
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
           ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request / writeback response channel of the load/store unit.
interface lsu_if #(
  parameter int TAG_W = 5
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;

  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_misaligned;
  logic             resp_fault;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_tag,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_tag, resp_misaligned, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_tag,
    output req_ready,
    output resp_valid, resp_rdata, resp_tag, resp_misaligned, resp_fault
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Combinational load formatter: selects the addressed lane of the memory
// word and sign- or zero-extends it according to funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rd_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  assign lane = rd_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = 32'd0;
    case (funct3_i)
      F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      F3_W:    data_o = lane;
      F3_BU:   data_o = {24'd0, lane[7:0]};
      F3_HU:   data_o = {16'd0, lane[15:0]};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one RV32I load or store at a time against a single-cycle
// byte-enabled data memory; illegal requests are answered without an access.
module lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = LSU_DEPTH_WORDS,
  parameter int TAG_W       = LSU_TAG_W
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_if.slave        req_if,
  output logic        mem_we_o,
  output logic [3:0]  mem_byteEnable_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  lsu_state_t       state_q;
  logic             store_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [TAG_W-1:0] tag_q;

  logic             resp_valid_q;
  logic [31:0]      resp_rdata_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic             resp_mis_q;
  logic             resp_fault_q;

  logic             req_mis;
  logic             req_fault;
  logic             range_bad;
  logic [31:0]      ld_data;
  logic [31:0]      resp_rdata_d;

  assign range_bad = (req_if.req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign req_mis   = misaligned(req_if.req_funct3, req_if.req_addr[1:0]);
  assign req_fault = !f3_legal(req_if.req_store, req_if.req_funct3) || range_bad;

  lsu_load_extend u_load_extend (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .rd_i      (mem_rd_i),
    .data_o    (ld_data)
  );

  assign resp_rdata_d = store_q ? 32'd0 : ld_data;

  // Request fields are captured only for legal accesses, so mem_a/mem_wd keep
  // the last issued access across error responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      tag_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_tag_q   <= '0;
      resp_mis_q   <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_if.req_valid) begin
            if (req_mis || req_fault) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'd0;
              resp_tag_q   <= req_if.req_tag;
              resp_mis_q   <= req_mis;
              resp_fault_q <= req_fault;
            end else begin
              store_q <= req_if.req_store;
              f3_q    <= req_if.req_funct3;
              addr_q  <= req_if.req_addr;
              wdata_q <= req_if.req_wdata;
              tag_q   <= req_if.req_tag;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= resp_rdata_d;
          resp_tag_q   <= tag_q;
          resp_mis_q   <= 1'b0;
          resp_fault_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_if.req_ready       = (state_q == IDLE);
  assign req_if.resp_valid      = resp_valid_q;
  assign req_if.resp_rdata      = resp_rdata_q;
  assign req_if.resp_tag        = resp_tag_q;
  assign req_if.resp_misaligned = resp_mis_q;
  assign req_if.resp_fault      = resp_fault_q;

  // Strobe decodes straight from the async-reset state so reset drops it at once.
  assign mem_we_o         = (state_q == ISSUE);
  assign mem_byteEnable_o = (state_q == ISSUE && store_q) ? be_gen(f3_q, addr_q[1:0]) : 4'b0000;
  assign mem_a_o          = addr_q;
  assign mem_wd_o         = wd_replicate(f3_q, wdata_q);

endmodule
